// File: rtl/ddr_cal_sequencer_if.sv
// ---------------------------------------------------------------------------
// ddr_cal_sequencer_if
// Request/acknowledge handshake between the DQ-calibration sequencer and the
// DDR command issuer.
//   WriteReq : sequencer -> issuer, request one calibration write burst
//   ReadReq  : sequencer -> issuer, request one calibration read burst
//   ReqAck   : issuer -> sequencer, one-cycle pulse, current request accepted
// ---------------------------------------------------------------------------
interface ddr_cal_sequencer_if;
   logic WriteReq;
   logic ReadReq;
   logic ReqAck;

   modport master (
      output WriteReq,
      output ReadReq,
      input  ReqAck
   );

   modport slave (
      input  WriteReq,
      input  ReadReq,
      output ReqAck
   );
endinterface

// File: rtl/ddr_cal_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_cal_sequencer
// Central DQ-calibration initiator (MCLK90 domain). Forces the all-'A' write
// pattern, requests one write and NREADS reads from the command issuer, lets
// the byte banks settle their delay taps, then collects every bank's CalFail.
//
// Ports:
//   MCLK90      clock
//   M90Reset    asynchronous active-high reset
//   Start       begin calibration (honoured only in Idle, Done or Fail)
//   CalFail     per-bank sticky failure flags
//   cmd         request/ack handshake to the command issuer (master side)
//   StartDQCal  one-cycle pulse to all banks before the read sweep
//   ForceA      banks drive 16'haaaa as write data
//   ReadCount   reads acknowledged so far (saturates at NREADS)
//   Busy        calibration in progress
//   CalDone     calibration passed (sticky until next Start)
//   CalError    calibration failed or timed out (sticky until next Start)
//   TimedOut    failure was a ReqAck timeout
//   FailBanks   CalFail snapshot taken in the Check state
// All outputs are registered: each is decoded from the next state and stored.
// ---------------------------------------------------------------------------
module ddr_cal_sequencer #(
   parameter int NBANKS      = 8,
   parameter int NREADS      = 64,
   parameter int READ_GAP    = 8,
   parameter int WR_HOLD     = 6,
   parameter int SETTLE      = 200,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic              MCLK90,
   input  logic              M90Reset,
   input  logic              Start,
   input  logic [NBANKS-1:0] CalFail,
   ddr_cal_sequencer_if.master cmd,
   output logic              StartDQCal,
   output logic              ForceA,
   output logic [6:0]        ReadCount,
   output logic              Busy,
   output logic              CalDone,
   output logic              CalError,
   output logic              TimedOut,
   output logic [NBANKS-1:0] FailBanks
);

   // One down-counter serves the write hold, the read gap and the settle wait.
   localparam int DLY_MAX = (SETTLE > READ_GAP)
                            ? ((SETTLE > WR_HOLD) ? SETTLE : WR_HOLD)
                            : ((READ_GAP > WR_HOLD) ? READ_GAP : WR_HOLD);
   localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);

   localparam logic [DLY_W-1:0] HOLD_LOAD   = DLY_W'(WR_HOLD - 1);
   localparam logic [DLY_W-1:0] GAP_LOAD    = DLY_W'(READ_GAP - 1);
   localparam logic [DLY_W-1:0] SETTLE_LOAD = DLY_W'(SETTLE - 1);
   localparam logic [9:0]       WAIT_LAST   = 10'(ACK_TIMEOUT - 1);
   localparam logic [6:0]       READS_LAST  = 7'(NREADS);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_HOLD,
      S_CAL_START,
      S_RD_REQ,
      S_RD_GAP,
      S_SETTLE,
      S_CHECK,
      S_DONE,
      S_FAIL
   } state_t;

   state_t            state, state_nxt;
   logic [DLY_W-1:0]  dly_cnt, dly_nxt;
   logic [9:0]        ack_wait, ack_wait_nxt;
   logic [6:0]        rd_cnt, rd_nxt, rd_inc;
   logic [NBANKS-1:0] fail_banks, fail_banks_nxt;
   logic              timed_out, timed_out_nxt;
   logic              write_req, read_req;
   logic              start_dq_nxt, force_a_nxt, write_req_nxt, read_req_nxt;
   logic              busy_nxt, cal_done_nxt, cal_error_nxt;

   assign rd_inc = rd_cnt + 7'd1;

   // Next-state and next-output decode
   always_comb begin
      state_nxt      = state;
      dly_nxt        = dly_cnt;
      ack_wait_nxt   = ack_wait;
      rd_nxt         = rd_cnt;
      fail_banks_nxt = fail_banks;
      timed_out_nxt  = timed_out;

      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (Start) begin
               state_nxt      = S_WR_REQ;
               ack_wait_nxt   = '0;
               rd_nxt         = '0;
               fail_banks_nxt = '0;
               timed_out_nxt  = 1'b0;
            end
         end
         S_WR_REQ: begin
            // An ack on the timeout cycle still wins.
            if (cmd.ReqAck) begin
               state_nxt = S_WR_HOLD;
               dly_nxt   = HOLD_LOAD;
            end else if (ack_wait == WAIT_LAST) begin
               state_nxt     = S_FAIL;
               timed_out_nxt = 1'b1;
            end else begin
               ack_wait_nxt = ack_wait + 10'd1;
            end
         end
         S_WR_HOLD: begin
            if (dly_cnt == '0) state_nxt = S_CAL_START;
            else               dly_nxt   = dly_cnt - 1'b1;
         end
         S_CAL_START: begin
            state_nxt    = S_RD_REQ;
            ack_wait_nxt = '0;
         end
         S_RD_REQ: begin
            if (cmd.ReqAck) begin
               rd_nxt = rd_inc;
               if (rd_inc == READS_LAST) begin
                  state_nxt = S_SETTLE;
                  dly_nxt   = SETTLE_LOAD;
               end else begin
                  state_nxt = S_RD_GAP;
                  dly_nxt   = GAP_LOAD;
               end
            end else if (ack_wait == WAIT_LAST) begin
               state_nxt     = S_FAIL;
               timed_out_nxt = 1'b1;
            end else begin
               ack_wait_nxt = ack_wait + 10'd1;
            end
         end
         S_RD_GAP: begin
            if (dly_cnt == '0) begin
               state_nxt    = S_RD_REQ;
               ack_wait_nxt = '0;
            end else begin
               dly_nxt = dly_cnt - 1'b1;
            end
         end
         S_SETTLE: begin
            if (dly_cnt == '0) state_nxt = S_CHECK;
            else               dly_nxt   = dly_cnt - 1'b1;
         end
         S_CHECK: begin
            // A bank failing mid-sweep only shows up here, never as an abort.
            fail_banks_nxt = CalFail;
            state_nxt      = (|CalFail) ? S_FAIL : S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase

      start_dq_nxt  = (state_nxt == S_CAL_START);
      force_a_nxt   = (state_nxt == S_WR_REQ) || (state_nxt == S_WR_HOLD);
      write_req_nxt = (state_nxt == S_WR_REQ);
      read_req_nxt  = (state_nxt == S_RD_REQ);
      busy_nxt      = !((state_nxt == S_IDLE) || (state_nxt == S_DONE) ||
                        (state_nxt == S_FAIL));
      cal_done_nxt  = (state_nxt == S_DONE);
      cal_error_nxt = (state_nxt == S_FAIL);
   end

   // State, counters and registered outputs
   always_ff @(posedge MCLK90 or posedge M90Reset) begin
      if (M90Reset) begin
         state      <= S_IDLE;
         dly_cnt    <= '0;
         ack_wait   <= '0;
         rd_cnt     <= '0;
         fail_banks <= '0;
         timed_out  <= 1'b0;
         StartDQCal <= 1'b0;
         ForceA     <= 1'b0;
         write_req  <= 1'b0;
         read_req   <= 1'b0;
         Busy       <= 1'b0;
         CalDone    <= 1'b0;
         CalError   <= 1'b0;
      end else begin
         state      <= state_nxt;
         dly_cnt    <= dly_nxt;
         ack_wait   <= ack_wait_nxt;
         rd_cnt     <= rd_nxt;
         fail_banks <= fail_banks_nxt;
         timed_out  <= timed_out_nxt;
         StartDQCal <= start_dq_nxt;
         ForceA     <= force_a_nxt;
         write_req  <= write_req_nxt;
         read_req   <= read_req_nxt;
         Busy       <= busy_nxt;
         CalDone    <= cal_done_nxt;
         CalError   <= cal_error_nxt;
      end
   end

   assign cmd.WriteReq = write_req;
   assign cmd.ReadReq  = read_req;
   assign ReadCount    = rd_cnt;
   assign FailBanks    = fail_banks;
   assign TimedOut     = timed_out;

endmodule

// File: tb/tb_ddr_cal_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ddr_cal_sequencer
// Directed bench for ddr_cal_sequencer with default parameters. A responder
// acks each request a programmable number of cycles after it rises; a
// negedge monitor records ack counts and the edge numbers of key events so
// the main sequence can compare them against hand-computed cycle distances.
// ---------------------------------------------------------------------------
module tb_ddr_cal_sequencer;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       Start   = 1'b0;
   logic [7:0] CalFail = 8'h00;

   logic       StartDQCal, ForceA, Busy, CalDone, CalError, TimedOut;
   logic [6:0] ReadCount;
   logic [7:0] FailBanks;

   ddr_cal_sequencer_if cmd();

   ddr_cal_sequencer #(
      .NBANKS(8), .NREADS(64), .READ_GAP(8), .WR_HOLD(6),
      .SETTLE(200), .ACK_TIMEOUT(1023)
   ) dut (
      .MCLK90     (clk),
      .M90Reset   (rst),
      .Start      (Start),
      .CalFail    (CalFail),
      .cmd        (cmd),
      .StartDQCal (StartDQCal),
      .ForceA     (ForceA),
      .ReadCount  (ReadCount),
      .Busy       (Busy),
      .CalDone    (CalDone),
      .CalError   (CalError),
      .TimedOut   (TimedOut),
      .FailBanks  (FailBanks)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ctrl_vec();
      return {24'b0, StartDQCal, ForceA, cmd.WriteReq, cmd.ReadReq,
              Busy, CalDone, CalError, TimedOut};
   endfunction

   // Responder: ack_delay=3 puts the ack on the third edge after the request
   // rises. Read number hold_idx uses hold_delay instead (0 = never ack).
   int ack_delay  = 3;
   int hold_idx   = 0;
   int hold_delay = 0;

   initial begin
      int age;
      int dly;
      age = 0;
      cmd.ReqAck = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cmd.WriteReq || cmd.ReadReq) begin
            age++;
            dly = (cmd.ReadReq && (int'(ReadCount) + 1 == hold_idx)) ? hold_delay : ack_delay;
            cmd.ReqAck = (dly != 0) && (age == dly);
         end else begin
            age = 0;
            cmd.ReqAck = 1'b0;
         end
      end
   end

   // Monitor; bumping mon_gen clears its records.
   int mon_gen = 0;
   int wr_acks, rd_acks, wr_ack_edge, last_rd_ack_edge, rd_rise_edge;
   int force_fall, dq_pulses, dq_at_first_rd, dq_width, dq_wmax;
   int gap_seen, gap_bad, done_edge, err_edge, overlap;

   initial begin
      int   seen_gen;
      logic p_rd, p_force, p_dq, p_done, p_err;
      seen_gen = -1;
      p_rd = 0; p_force = 0; p_dq = 0; p_done = 0; p_err = 0;
      forever begin
         @(negedge clk);
         if (seen_gen != mon_gen) begin
            seen_gen = mon_gen;
            wr_acks = 0; rd_acks = 0; wr_ack_edge = 0; last_rd_ack_edge = 0;
            rd_rise_edge = 0; force_fall = 0; dq_pulses = 0; dq_at_first_rd = -1;
            dq_width = 0; dq_wmax = 0; gap_seen = 0; gap_bad = 0;
            done_edge = 0; err_edge = 0; overlap = 0;
            p_rd = cmd.ReadReq; p_force = ForceA; p_dq = StartDQCal;
            p_done = CalDone; p_err = CalError;
         end
         if (cmd.ReqAck && cmd.WriteReq) begin
            wr_acks++;
            wr_ack_edge = cyc + 1;
         end
         if (cmd.ReqAck && cmd.ReadReq) begin
            rd_acks++;
            last_rd_ack_edge = cyc + 1;
         end
         if (cmd.ReadReq && !p_rd) begin
            rd_rise_edge = cyc;
            if (rd_acks == 0) dq_at_first_rd = dq_pulses;
            else begin
               gap_seen++;
               if (cyc - last_rd_ack_edge != 8) gap_bad++;
            end
         end
         if (!ForceA && p_force) force_fall = cyc;
         if (StartDQCal && !p_dq) dq_pulses++;
         if (StartDQCal) dq_width++;
         else            dq_width = 0;
         if (dq_width > dq_wmax) dq_wmax = dq_width;
         if (CalDone && !p_done)  done_edge = cyc;
         if (CalError && !p_err)  err_edge = cyc;
         if (cmd.WriteReq && cmd.ReadReq) overlap++;
         p_rd = cmd.ReadReq; p_force = ForceA; p_dq = StartDQCal;
         p_done = CalDone; p_err = CalError;
      end
   end

   task automatic new_run();
      mon_gen++;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 Start = 1'b1;
      @(posedge clk); #1 Start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(CalDone || CalError) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, {31'b0, CalDone | CalError}, 1);
      @(negedge clk);
   endtask

   task automatic wait_reads(input string tag, input int target);
      int n;
      n = 0;
      while (rd_acks < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, rd_acks, target);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", ctrl_vec(), 0);
      check_eq("rst_readcount", {25'b0, ReadCount}, 0);
      check_eq("rst_failbanks", {24'b0, FailBanks}, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Nominal run
      new_run();
      pulse_start();
      @(negedge clk);
      check_eq("nom_writereq_after_start", {31'b0, cmd.WriteReq}, 1);
      check_eq("nom_busy", {31'b0, Busy}, 1);
      wait_end("nom_end");
      check_eq("nom_wr_acks", wr_acks, 1);
      check_eq("nom_rd_acks", rd_acks, 64);
      check_eq("nom_forcea_hold", force_fall - wr_ack_edge, 6);
      check_eq("nom_dq_pulses", dq_pulses, 1);
      check_eq("nom_dq_before_read", dq_at_first_rd, 1);
      check_eq("nom_dq_width", dq_wmax, 1);
      check_eq("nom_gaps_seen", gap_seen, 63);
      check_eq("nom_gap_bad", gap_bad, 0);
      // Check state is entered 200 edges after the last ack; CalDone one later.
      check_eq("nom_settle", done_edge - last_rd_ack_edge, 201);
      check_eq("nom_overlap", overlap, 0);
      check_eq("nom_flags", {28'b0, Busy, CalDone, CalError, TimedOut}, 32'b0100);
      check_eq("nom_readcount", {25'b0, ReadCount}, 64);
      check_eq("nom_failbanks", {24'b0, FailBanks}, 0);

      // Start pulses during RdGap and Settle are ignored
      new_run();
      pulse_start();
      wait_reads("sp_reads10", 10);
      pulse_start();
      @(negedge clk);
      check_eq("sp_gap_noreq", {30'b0, cmd.WriteReq, cmd.ReadReq}, 0);
      check_eq("sp_gap_count", {25'b0, ReadCount}, 10);
      wait_reads("sp_reads64", 64);
      repeat (20) @(negedge clk);
      pulse_start();
      @(negedge clk);
      check_eq("sp_settle_state", {29'b0, cmd.WriteReq, Busy, CalDone}, 32'b010);
      wait_end("sp_end");
      check_eq("sp_done", {30'b0, CalDone, CalError}, 32'b10);
      check_eq("sp_wr_acks", wr_acks, 1);
      check_eq("sp_settle", done_edge - last_rd_ack_edge, 201);
      // Restart from Done
      new_run();
      pulse_start();
      @(negedge clk);
      check_eq("restart_writereq", {31'b0, cmd.WriteReq}, 1);
      check_eq("restart_cleared", {25'b0, ReadCount, CalDone, Busy}, 32'b01);

      // CalFail raised after read 20 (run continues from the restart above)
      new_run();
      wait_reads("cf_reads20", 20);
      @(posedge clk); #1 CalFail = 8'h04;
      wait_end("cf_end");
      check_eq("cf_rd_acks", rd_acks, 64);
      check_eq("cf_flags", {29'b0, CalDone, CalError, TimedOut}, 32'b010);
      check_eq("cf_failbanks", {24'b0, FailBanks}, 32'h04);
      CalFail = 8'h00;

      // ReqAck withheld on read 10
      hold_idx = 10; hold_delay = 0;
      new_run();
      pulse_start();
      wait_end("to_end");
      check_eq("to_flags", {29'b0, CalDone, CalError, TimedOut}, 32'b011);
      check_eq("to_delay", err_edge - rd_rise_edge, 1023);
      check_eq("to_reqs", {29'b0, cmd.ReadReq, cmd.WriteReq, ForceA}, 0);
      check_eq("to_readcount", {25'b0, ReadCount}, 9);

      // Ack exactly on the timeout cycle wins
      hold_delay = 1023;
      new_run();
      pulse_start();
      wait_end("bd_end");
      check_eq("bd_flags", {29'b0, CalDone, CalError, TimedOut}, 32'b100);
      check_eq("bd_readcount", {25'b0, ReadCount}, 64);
      hold_idx = 0;

      // Reset in RdReq with ReadCount=30
      new_run();
      pulse_start();
      n = 0;
      while (!(ReadCount == 7'd30 && cmd.ReadReq) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq("rs_reached30", {25'b0, ReadCount}, 30);
      #2 rst = 1'b1;
      #1;
      check_eq("rs_async_ctrl", ctrl_vec(), 0);
      check_eq("rs_async_count", {25'b0, ReadCount}, 0);
      repeat (3) @(negedge clk);
      check_eq("rs_held_ctrl", ctrl_vec(), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rs_idle_after", ctrl_vec(), 0);
      new_run();
      pulse_start();
      wait_end("rs_fresh_end");
      check_eq("rs_fresh_acks", {wr_acks[15:0], rd_acks[15:0]}, {16'd1, 16'd64});
      check_eq("rs_fresh_flags", {29'b0, CalDone, CalError, TimedOut}, 32'b100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_cal_sequencer.md
Name: ddr_cal_sequencer

Overview:
- Central DQ-calibration initiator for the DDR controller, in the MCLK90 domain.
- Drives the per-bank calibration inputs (StartDQCal, ForceA) and requests one all-'A' pattern write, then NREADS pattern reads, through the command issuer's request/acknowledge handshake.
- After the banks have had time to settle their delay taps, it collects every bank's CalFail flag and reports done, fail or timeout to the init/boot logic.

Parameters:
NBANKS, 8, number of DQS/DQ byte banks whose CalFail is collected
NREADS, 64, calibration reads issued (one per delay tap)
READ_GAP, 8, idle cycles between a read ack and the next ReadReq (at least 2, so the banks can consume each burst)
WR_HOLD, 6, cycles ForceA stays high after the write ack so the forced data reaches the pins
SETTLE, 200, cycles after the last read ack before CalFail is sampled (covers bank DecWS/DecWW tap stepping)
ACK_TIMEOUT, 1023, cycles a request may wait for ReqAck before aborting

Ports:
MCLK90  in  1  clock
M90Reset  in  1  asynchronous, active-high reset
Start  in  1  begin calibration; level or pulse, sampled only in Idle, Done or Fail
ReqAck  in  1  one-cycle pulse from the command issuer: the current WriteReq/ReadReq was accepted
CalFail  in  NBANKS  per-bank sticky failure flags
StartDQCal  out  1  one-cycle pulse to all banks
ForceA  out  1  all banks drive 16'haaaa as write data
WriteReq  out  1  request one calibration write burst
ReadReq  out  1  request one calibration read burst
ReadCount  out  7  reads acknowledged so far
Busy  out  1  calibration in progress
CalDone  out  1  calibration passed (sticky until next Start)
CalError  out  1  calibration failed or timed out (sticky until next Start)
TimedOut  out  1  failure was caused by a ReqAck timeout
FailBanks  out  NBANKS  snapshot of CalFail taken in the Check state

Behaviour:
- All outputs are registered.
- Reset values: state Idle; all outputs 0; internal counters 0. Reset mid-operation returns to Idle immediately with all requests and ForceA low, and no further requests are issued.
- States: Idle, WrReq, WrHold, CalStart, RdReq, RdGap, Settle, Check, Done, Fail.
- Idle/Done/Fail, Start=1:
  - Next cycle go to WrReq.
  - Clear ReadCount, CalDone, CalError, TimedOut and FailBanks.
  - Set Busy=1.
- WrReq:
  - WriteReq=1 and ForceA=1.
  - ReqAck → WrHold with hold counter = WR_HOLD-1. WriteReq is low from the cycle after the ack.
- WrHold:
  - ForceA stays 1.
  - Counter reaches 0 → CalStart; ForceA drops on entering CalStart.
- CalStart: StartDQCal=1 for exactly one cycle → RdReq.
- RdReq:
  - ReadReq=1.
  - ReqAck → ReadCount increments. If the new count equals NREADS → Settle with counter SETTLE-1; otherwise → RdGap with counter READ_GAP-1.
  - ReadReq is low from the cycle after the ack.
- RdGap: counter reaches 0 → RdReq.
- Settle: counter reaches 0 → Check.
- Check:
  - FailBanks <= CalFail.
  - If CalFail is all zero → Done (CalDone=1); otherwise → Fail (CalError=1).
  - Busy=0 in both Done and Fail.
- Timeout:
  - A 10-bit wait counter clears on entry to WrReq/RdReq and increments each cycle while waiting.
  - Reaching ACK_TIMEOUT without an ack → Fail with CalError=1, TimedOut=1, requests dropped and ForceA=0.
  - A ReqAck arriving in the same cycle the timeout is reached wins; no timeout is flagged.
- ReqAck outside WrReq/RdReq is ignored.
- CalFail rising mid-sequence does not abort. All NREADS reads are still issued so the other banks complete their sweeps.
- Start while Busy is ignored.
- ReadCount saturates at NREADS and holds its value in Done/Fail until the next Start.
- Request issue rate: at most one request outstanding, never two requests in the same cycle.

Test Plan:
- Nominal, ReqAck 3 cycles after each request, CalFail=0:
  - Exactly 1 write and 64 read acks.
  - ForceA high through write ack+6.
  - StartDQCal a single pulse before the first ReadReq.
  - CalDone=1, CalError=0, ReadCount=64, FailBanks=0.
- CalFail=8'h04 asserted after read 20:
  - All 64 reads still issued.
  - After Settle: CalError=1, CalDone=0, FailBanks=8'h04, TimedOut=0.
- ReqAck withheld on read 10:
  - Exactly 1023 cycles after ReadReq rises: CalError=1, TimedOut=1, ReadReq=0, ReadCount=9.
  - ReqAck on the boundary cycle instead → no timeout.
- Start pulsed during RdGap and Settle:
  - No effect.
  - Restart from Done: counters clear and a new write request appears one cycle after Start.
- M90Reset asserted in RdReq with ReadCount=30:
  - All outputs 0 asynchronously.
  - After release, Start begins a full fresh sequence.
- Gap check, READ_GAP=8:
  - Every read ack to next ReadReq rise is exactly 8 cycles.
  - Last read ack to Check is exactly 200 cycles.
